fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of the PC and PCPlus4 fields.
REQ-002 SHALL have parameter DEPTH, default 4: number of queue entries; power of two, at least 2.
REQ-003 SHALL have parameter BYPASS, default 0: 1 enables empty-queue pass-through from input to output in the same cycle.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  discard all entries (driven from the EX-stage redirect, PCSrcE).
REQ-007 SHALL have port in_valid  input  1  fetch stage presents an entry.
REQ-008 SHALL have port in_ready  output  1  queue can accept an entry this cycle.
REQ-009 SHALL have ports in_pc  input  XLEN, in_pcplus4  input  XLEN, in_instr  input  32: entry payload.
REQ-010 SHALL have port out_valid  output  1  head entry is valid for decode.
REQ-011 SHALL have port out_ready  input  1  decode consumes the head entry (driven as ~StallD).
REQ-012 SHALL have ports out_pc  output  XLEN, out_pcplus4  output  XLEN, out_instr  output  32: head payload.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL accept a push when in_valid && in_ready, and pop the head when out_valid && out_ready.
REQ-015 SHALL drive in_ready = (count != DEPTH); in_ready SHALL NOT depend combinationally on out_ready, so a push is refused when full even if a pop occurs in the same cycle.
REQ-016 SHALL drive out_valid = (count != 0) && !flush when BYPASS=0.
REQ-017 SHALL present entries strictly in push order, with 1-cycle latency from push to out_valid when BYPASS=0.
REQ-018 SHALL keep count unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-019 SHALL use read/write pointers $clog2(DEPTH) wide that wrap from DEPTH-1 to 0 without a gap.
REQ-020 SHALL, on flush, set count, read pointer and write pointer to 0 on the next edge; a push offered in the same cycle SHALL be discarded, and no pop SHALL be signalled (out_valid=0 in the flush cycle).
REQ-021 SHALL, when BYPASS=1 and count==0 and !flush, drive out_valid=in_valid and out_* = in_*; if out_ready is also high, the entry SHALL NOT be written and count SHALL stay 0.
REQ-022 SHALL, when BYPASS=1, count==0 and out_ready=0, store the pushed entry normally.
REQ-023 SHALL drive out_instr = 0x00000013 (NOP) and out_pc = out_pcplus4 = 0 whenever out_valid=0.
REQ-024 SHALL hold the payload of a stalled head (out_valid=1, out_ready=0) stable until it is popped or flushed.

Reset
REQ-025 SHALL, on reset, set count=0, both pointers=0, out_valid=0, out_instr=0x00000013 and out_pc=out_pcplus4=0 on the next edge.
REQ-026 SHALL give reset priority over flush, push and pop in the same cycle.
REQ-027 SHALL drive in_ready=1 in the first cycle after reset is released.
REQ-028 SHALL not reset storage contents; correctness SHALL rely only on the pointers and count.

Structure
REQ-029 SHALL take the constant NOP_INSTR (0x00000013) and the typedef fq_entry_t (pc, pcplus4, instr) from the shared package fetch_pkg.
REQ-030 SHALL place entry storage in the sub-module fq_storage: DEPTH x fq_entry_t array, one synchronous write port, one combinational read port.
REQ-031 SHALL keep pointer, count, bypass and output-masking logic in fetch_queue.

Verification
REQ-032 Reset, DEPTH=4, out_ready=0, push pc 0x0/0x4/0x8/0xC -> in_ready=0 after the fourth push, count=4; then out_ready=1 -> pops 0x0, 0x4, 0x8, 0xC in order.
REQ-033 count=2, in_valid=1 and out_ready=1 for 3 cycles -> count stays 2 and pops continue in order.
REQ-034 count=3, flush=1 with in_valid=1 (pc 0x40) -> next cycle count=0, out_valid=0, out_instr=0x00000013, and 0x40 is never popped.
REQ-035 DEPTH=4, 10 consecutive pushes/pops (pc 0x0..0x24) with random out_ready -> exact order preserved across pointer wrap, no loss and no duplicates.
REQ-036 BYPASS=1, empty, in_valid with pc 0x100, out_ready=1 -> out_valid=1 and out_pc=0x100 in the same cycle, count stays 0; BYPASS=0 under the same stimulus -> out_valid the next cycle.
REQ-037 Reset asserted at count=3 together with a push and a flush -> next cycle count=0, in_ready=1, out_valid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-queue entry type and NOP constant.
package fetch_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    // Entry fields are sized for the widest supported XLEN; the queue zero-extends and truncates.
    localparam int FQ_XLEN = 64;
    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] pcplus4;
        logic [31:0]        instr;
    } fq_entry_t;
endpackage

// File: rtl/fq_storage.sv
// fq_storage: entry array with one synchronous write port and one combinational read port.
module fq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    input  fq_entry_t                i_wdata,
    output fq_entry_t                o_rdata
);
    fq_entry_t r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch-to-decode entry queue with flush, optional empty-queue bypass and NOP masking.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_pcplus4,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_pcplus4,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [PW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;
    fq_entry_t     w_wdata, w_head;
    logic          w_empty, w_bypass, w_push, w_pop;
    fq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_raddr (r_rd_ptr),
        .i_wdata (w_wdata),
        .o_rdata (w_head)
    );
    always_comb begin
        w_empty     = r_count == '0;
        w_bypass    = (BYPASS != 0) && w_empty && !flush;
        in_ready    = r_count != CW'(DEPTH);
        out_valid   = w_bypass ? in_valid : (!w_empty && !flush);
        // A bypassed entry consumed this cycle never touches storage.
        w_push      = in_valid && in_ready && !flush && !(w_bypass && out_ready);
        w_pop       = !w_empty && !flush && out_ready;
        w_wdata     = '{pc: FQ_XLEN'(in_pc), pcplus4: FQ_XLEN'(in_pcplus4), instr: in_instr};
        out_pc      = !out_valid ? '0 : w_bypass ? in_pc : XLEN'(w_head.pc);
        out_pcplus4 = !out_valid ? '0 : w_bypass ? in_pcplus4 : XLEN'(w_head.pcplus4);
        out_instr   = !out_valid ? NOP_INSTR : w_bypass ? in_instr : w_head.instr;
    end
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
    assign count = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scoreboard bench for fetch_queue (BYPASS=0 main DUT, BYPASS=1 side DUT).
module tb_fetch_queue;
    import fetch_pkg::*;
    logic        clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_pc = 0, in_pcplus4 = 0, in_instr = 0;
    logic        in_ready, out_valid, b_in_ready, b_out_valid;
    logic [31:0] out_pc, out_pcplus4, out_instr, b_out_pc, b_out_pcplus4, b_out_instr;
    logic [2:0]  count, b_count;
    logic [31:0] exp_q[$];
    int          n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(0)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pcplus4(in_pcplus4), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_pcplus4(out_pcplus4), .out_instr(out_instr), .count(count)
    );
    fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_pc(in_pc), .in_pcplus4(in_pcplus4), .in_instr(in_instr),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
        .out_pcplus4(b_out_pcplus4), .out_instr(b_out_instr), .count(b_count)
    );

    function automatic logic [31:0] ins(logic [31:0] p);
        return 32'hA000_0000 ^ p;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(logic v, logic [31:0] p);
        in_valid   = v;
        in_pc      = p;
        in_pcplus4 = p + 32'd4;
        in_instr   = ins(p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed head is matched against the scoreboard; idle output must be a NOP.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pop: got pc %0h expected no entry", out_pc);
                end else begin
                    automatic logic [31:0] e = exp_q.pop_front();
                    chk("pop_pc", out_pc, e);
                    chk("pop_pcplus4", out_pcplus4, e + 32'd4);
                    chk("pop_instr", out_instr, ins(e));
                end
            end else if (!out_valid) begin
                chk("idle_nop", out_instr, NOP_INSTR);
                chk("idle_pc", out_pc, 0);
            end
        end
    end

    initial begin
        step();
        step();
        reset = 0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, NOP_INSTR);
        chk("rst_out_pcplus4", out_pcplus4, 0);

        // Fill to DEPTH with decode stalled
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'(k * 4));
            exp_q.push_back(32'(k * 4));
            if (k == 0) begin
                #1;
                chk("latency_before", out_valid, 0);
            end
            step();
            if (k == 0) chk("latency_after", out_valid, 1);
        end
        drive(0, 0);
        #1;
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("stall_head_pc", out_pc, 0);
        // Full with a pop: push still refused
        drive(1, 32'h50);
        out_ready = 1;
        #1;
        chk("full_pop_in_ready", in_ready, 0);
        step();
        chk("full_pop_count", count, 3);
        drive(0, 0);
        repeat (3) step();
        chk("drain_count", count, 0);

        // Simultaneous push and pop hold count
        out_ready = 0;
        drive(1, 32'h10); exp_q.push_back(32'h10); step();
        drive(1, 32'h14); exp_q.push_back(32'h14); step();
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h18 + 32'(k * 4));
            exp_q.push_back(32'h18 + 32'(k * 4));
            step();
            chk("pushpop_count", count, 2);
        end
        drive(0, 0);
        repeat (2) step();
        chk("pushpop_drain", count, 0);

        // Flush discards stored entries and the concurrent push
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h30 + 32'(k * 4));
            exp_q.push_back(32'h30 + 32'(k * 4));
            step();
        end
        chk("preflush_count", count, 3);
        flush = 1;
        drive(1, 32'h40);
        exp_q.delete();
        #1;
        chk("flush_cycle_valid", out_valid, 0);
        step();
        flush = 0;
        drive(0, 0);
        #1;
        chk("postflush_count", count, 0);
        chk("postflush_valid", out_valid, 0);
        chk("postflush_instr", out_instr, NOP_INSTR);
        out_ready = 1;
        repeat (2) step();

        // Pointer wrap with random decode stalls
        begin
            int sent = 0, cyc = 0;
            while (sent < 10 && cyc < 200) begin
                drive(1, 32'(sent * 4));
                out_ready = 1'($urandom_range(0, 1));
                #1;
                if (in_ready) begin
                    exp_q.push_back(32'(sent * 4));
                    sent++;
                end
                step();
                cyc++;
            end
            if (sent < 10) begin
                n_total++;
                $display("FAIL wrap_push_timeout: got %0d pushes expected 10", sent);
            end
            drive(0, 0);
            out_ready = 1;
            cyc = 0;
            while (count != 0 && cyc < 50) begin
                step();
                cyc++;
            end
            chk("wrap_drained", count, 0);
            chk("wrap_sb_empty", 64'(exp_q.size()), 0);
        end

        // Bypass vs registered path
        reset = 1;
        step();
        reset = 0;
        exp_q.delete();
        drive(1, 32'h100);
        exp_q.push_back(32'h100);
        out_ready = 1;
        #1;
        chk("byp_valid", b_out_valid, 1);
        chk("byp_pc", b_out_pc, 32'h100);
        chk("byp_instr", b_out_instr, ins(32'h100));
        chk("nobyp_valid_same", out_valid, 0);
        step();
        drive(0, 0);
        #1;
        chk("byp_count", b_count, 0);
        chk("nobyp_valid_next", out_valid, 1);
        chk("nobyp_pc_next", out_pc, 32'h100);
        step();
        out_ready = 0;
        drive(1, 32'h200);
        exp_q.push_back(32'h200);
        #1;
        chk("byp_stall_valid", b_out_valid, 1);
        step();
        drive(0, 0);
        #1;
        chk("byp_stall_count", b_count, 1);
        chk("byp_stall_pc", b_out_pc, 32'h200);
        out_ready = 1;
        step();
        chk("byp_drain_count", b_count, 0);

        // Reset beats flush and push
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h300 + 32'(k * 4));
            exp_q.push_back(32'h300 + 32'(k * 4));
            step();
        end
        chk("prerst_count", count, 3);
        reset = 1;
        flush = 1;
        drive(1, 32'h30C);
        exp_q.delete();
        step();
        reset = 0;
        flush = 0;
        drive(0, 0);
        #1;
        chk("rst_pri_count", count, 0);
        chk("rst_pri_in_ready", in_ready, 1);
        chk("rst_pri_valid", out_valid, 0);
        out_ready = 1;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
